mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter READ_WAIT, default 3, cycles mem_read is held before read data is sampled; 3 covers the 7 ns memory read delay at a 2.5 ns clock; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 m0_req, m1_req  input  1 each  access request from requester 0 (CPU) / 1 (loader-DMA); held until the matching ready.
REQ-005 m0_we, m1_we  input  1 each  1 = write, 0 = read; valid while req is high.
REQ-006 m0_addr, m1_addr  input  32 each  byte address; valid while req is high.
REQ-007 m0_wdata, m1_wdata  input  32 each  write data; valid while req is high.
REQ-008 m0_ready, m1_ready  output  1 each  one-cycle completion pulse to the owning requester.
REQ-009 rdata  output  32  read data shared by both requesters; valid in the cycle ready is high.
REQ-010 mem_read, mem_write  output  1 each  memory strobes.
REQ-011 mem_addr, mem_write_data  output  32 each  memory address and write data.
REQ-012 mem_read_data  input  32  asynchronous memory read data.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, READ, WRITE, DONE.
REQ-014 IDLE: if no req is high, the FSM SHALL stay in IDLE; otherwise it SHALL grant one requester, latch its addr, wdata, we and owner id, and go to READ (we=0) or WRITE (we=1).
REQ-015 Arbitration SHALL be round-robin: when only one req is high, that requester wins; when both are high, the requester not granted last wins; after reset requester 0 wins the first tie.
REQ-016 READ: mem_read=1 and mem_addr=latched address for exactly READ_WAIT cycles, counted by a wait counter; at the edge ending the last READ cycle, mem_read_data SHALL be captured into rdata and the FSM SHALL go to DONE.
REQ-017 WRITE: mem_write=1, with mem_addr and mem_write_data taken from the latched values, for exactly one cycle, then DONE.
REQ-018 DONE: the owner's ready SHALL be 1 for exactly one cycle; the last-granted id SHALL be updated; the next state SHALL be IDLE.
REQ-019 Latency, measured from the edge at which req is sampled in IDLE: read ready SHALL rise READ_WAIT+1 cycles later; write ready SHALL rise 2 cycles later.
REQ-020 A requester SHALL deassert req, or present a new request, at the edge ending its ready cycle; IDLE re-samples req, so the minimum spacing between back-to-back grants is one IDLE cycle.
REQ-021 Changes to req, addr, we or wdata after a grant SHALL NOT affect the in-flight transaction; a req dropped mid-transaction still completes and still receives ready.
REQ-022 mem_read and mem_write SHALL never be high in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-023 m0_ready and m1_ready SHALL never be high in the same cycle.
REQ-024 rdata SHALL hold its last captured value until the next read completes; writes SHALL NOT alter it.

Reset
REQ-025 While reset is 1 at a posedge, the FSM SHALL go to IDLE and clear the wait counter, and rdata, the latched address/data and last-granted id SHALL clear to 0 (next tie goes to requester 0).
REQ-026 mem_write SHALL be gated by ~reset, so a write aborted by reset never commits to memory.
REQ-027 Reset mid-transaction SHALL drop the transaction with no ready pulse; all outputs SHALL be 0 from the cycle after the reset edge.

Structure
REQ-028 State encodings, owner ids and the READ_WAIT default SHALL live in the shared package mem_arb_pkg.
REQ-029 The wait-state counter SHALL be a separate sub-module, mem_wait_counter, with load, enable and a terminal-count output.

Verification
REQ-030 m0 reads 0x000000C8, memory word 50 = 0x12345678, READ_WAIT=3 -> mem_read high 3 cycles; m0_ready 4 cycles after grant; rdata=0x12345678.
REQ-031 m1 writes 0xDEADBEEF to 0x000000CC -> mem_write high exactly 1 cycle; word 51 = 0xDEADBEEF; m1_ready 2 cycles after grant.
REQ-032 m0 and m1 requests rise in the same cycle, both held for 4 requests each -> grants alternate m0,m1,m0,m1...; no ready overlap.
REQ-033 Reset asserted during WRITE of 0xFFFFFFFF to word 52 -> word 52 unchanged, no ready, FSM in IDLE, all outputs 0.
REQ-034 m0 changes addr from 0xC8 to 0xD0 one cycle after grant -> memory access still uses 0xC8.
REQ-035 READ_WAIT=1, back-to-back m0 reads of 0xC8 and 0xCC -> each ready 2 cycles after its grant; one IDLE cycle between the two transactions.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encodings, owner ids and round-robin pick for mem_arbiter
package mem_arb_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_M0   = 2'd1;
    localparam logic [1:0] OWN_M1   = 2'd2;
    localparam int READ_WAIT_DEF = 3;
    localparam int WAIT_W = 4;
    function automatic logic [1:0] rr_pick(input logic r0, input logic r1, input logic [1:0] last);
        return (r0 && r1) ? ((last == OWN_M0) ? OWN_M1 : OWN_M0) : r1 ? OWN_M1 : r0 ? OWN_M0 : OWN_NONE;
    endfunction
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter flagging the last wait cycle
module mem_wait_counter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              enable,
    input  logic [WAIT_W-1:0] load_value,
    output logic              tc
);
    logic [WAIT_W-1:0] count;
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (load) count <= load_value;
        else if (enable && count != '0) count <= count - 1'b1;
    end
    assign tc = count == WAIT_W'(1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter granting two requesters single-word memory accesses
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int READ_WAIT = READ_WAIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m0_ready,
    output logic        m1_ready,
    output logic [31:0] rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    logic [1:0]  state, state_nx, owner, last, pick;
    logic [31:0] addr_q, wdata_q;
    logic        sel_we, start, wait_tc;
    assign pick   = rr_pick(m0_req, m1_req, last);
    assign sel_we = (pick == OWN_M1) ? m1_we : m0_we;
    assign start  = state == S_IDLE && pick != OWN_NONE;
    mem_wait_counter u_wait (
        .clk        (clk),
        .reset      (reset),
        .load       (start && !sel_we),
        .enable     (state == S_READ),
        .load_value (WAIT_W'(READ_WAIT)),
        .tc         (wait_tc)
    );
    always_comb begin
        state_nx = S_IDLE;
        if (state == S_IDLE) state_nx = start ? (sel_we ? S_WRITE : S_READ) : S_IDLE;
        else if (state == S_READ) state_nx = wait_tc ? S_DONE : S_READ;
        else if (state == S_WRITE) state_nx = S_DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            owner   <= OWN_NONE;
            last    <= OWN_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                owner   <= pick;
                addr_q  <= (pick == OWN_M1) ? m1_addr : m0_addr;
                wdata_q <= (pick == OWN_M1) ? m1_wdata : m0_wdata;
            end
            if (state == S_READ && wait_tc) rdata <= mem_read_data;
            if (state == S_DONE) last <= owner;
        end
    end
    assign mem_read       = state == S_READ;
    // gated so a write interrupted by reset never reaches memory
    assign mem_write      = state == S_WRITE && !reset;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign m0_ready       = state == S_DONE && owner == OWN_M0;
    assign m1_ready       = state == S_DONE && owner == OWN_M1;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter with behavioural memories
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ready, m1_ready, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_write_data, mem_read_data;
    logic        b_m0_ready, b_m1_ready, b_mem_read, b_mem_write;
    logic [31:0] b_rdata, b_mem_addr, b_mem_write_data, b_mem_read_data;
    logic [31:0] mem [0:63];
    logic [31:0] mem1 [0:63];
    int n_vec = 0;
    int n_err = 0;
    mem_arbiter #(.READ_WAIT(3)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ready(m0_ready), .m1_ready(m1_ready), .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );
    mem_arbiter #(.READ_WAIT(1)) u_rw1 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ready(b_m0_ready), .m1_ready(b_m1_ready), .rdata(b_rdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
        .mem_write_data(b_mem_write_data), .mem_read_data(b_mem_read_data)
    );
    always #5 clk = ~clk;
    assign mem_read_data   = mem[mem_addr[7:2]];
    assign b_mem_read_data = mem1[b_mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_write_data;
        if (b_mem_write) mem1[b_mem_addr[7:2]] <= b_mem_write_data;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    always @(negedge clk)
        if (!reset)
            check("excl", {28'b0, mem_read & mem_write, m0_ready & m1_ready,
                           b_mem_read & b_mem_write, b_m0_ready & b_m1_ready}, 32'h0);
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input bit m, input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask
    // one transaction on u_dut from an IDLE start; lat counts edges until ready is seen
    task automatic do_txn(input bit m, input bit we, input logic [31:0] a, input logic [31:0] d, input bit disturb,
                          output int lat, output int nrd, output int nwr, output logic [31:0] rd,
                          output logic [31:0] sa);
        drive(m, 1'b1, we, a, d);
        lat = 0; nrd = 0; nwr = 0; rd = '0; sa = '0;
        while (lat < 20) begin
            tick();
            lat++;
            nrd += int'(mem_read);
            nwr += int'(mem_write);
            if (mem_read || mem_write) sa = mem_addr;
            if (m ? m1_ready : m0_ready) begin
                rd = rdata;
                break;
            end
            if (disturb && lat == 1) drive(m, 1'b0, ~we, a ^ 32'h18, ~d);
        end
        drive(m, 1'b0, 1'b0, '0, '0);
        tick();
    endtask
    int lat, nrd, nwr, np, c0, c1, t;
    int order [8];
    logic [31:0] rd, sa;
    initial begin
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            mem1[i] = '0;
        end
        mem[50] = 32'h12345678;
        mem[52] = 32'hCAFEF00D;
        tick();
        tick();
        check("rst_m0_ready", m0_ready, 0);
        check("rst_m1_ready", m1_ready, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rdata", rdata, 0);
        reset = 1'b0;
        tick();
        check("idle_mem_read", mem_read, 0);
        do_txn(0, 0, 32'hC8, '0, 0, lat, nrd, nwr, rd, sa);
        check("rd_lat", lat, 4);
        check("rd_strobes", nrd, 3);
        check("rd_no_write", nwr, 0);
        check("rd_addr", sa, 32'hC8);
        check("rd_data", rd, 32'h12345678);
        do_txn(1, 1, 32'hCC, 32'hDEADBEEF, 0, lat, nrd, nwr, rd, sa);
        check("wr_lat", lat, 2);
        check("wr_strobes", nwr, 1);
        check("wr_no_read", nrd, 0);
        check("wr_addr", sa, 32'hCC);
        check("wr_mem51", mem[51], 32'hDEADBEEF);
        check("wr_rdata_hold", rdata, 32'h12345678);
        do_txn(0, 0, 32'hC8, '0, 1, lat, nrd, nwr, rd, sa);
        check("dist_lat", lat, 4);
        check("dist_addr", sa, 32'hC8);
        check("dist_data", rd, 32'h12345678);
        check("dist_no_write", nwr, 0);
        drive(1, 1, 1, 32'hD0, 32'hFFFFFFFF);
        tick();
        check("abort_in_write", mem_write, 1);
        reset = 1'b1;
        #1;
        check("abort_gated", mem_write, 0);
        drive(1, 0, 0, '0, '0);
        tick();
        check("abort_mem52", mem[52], 32'hCAFEF00D);
        check("abort_m1_ready", m1_ready, 0);
        check("abort_mem_write", mem_write, 0);
        check("abort_mem_read", mem_read, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_wdata", mem_write_data, 0);
        check("abort_rdata", rdata, 0);
        reset = 1'b0;
        tick();
        check("abort_no_ready", {30'b0, m0_ready, m1_ready}, 0);
        drive(0, 1, 0, 32'hC8, '0);
        drive(1, 1, 0, 32'hCC, '0);
        np = 0; c0 = 0; c1 = 0; t = 0;
        while (np < 8 && t < 80) begin
            tick();
            t++;
            if (m0_ready) begin
                if (np < 8) order[np] = 0;
                np++; c0++;
                check("rr_rdata0", rdata, 32'h12345678);
                if (c0 == 4) m0_req = 1'b0;
            end
            if (m1_ready) begin
                if (np < 8) order[np] = 1;
                np++; c1++;
                check("rr_rdata1", rdata, 32'hDEADBEEF);
                if (c1 == 4) m1_req = 1'b0;
            end
        end
        check("rr_count", np, 8);
        for (int i = 0; i < 8; i++) check("rr_order", order[i], i % 2);
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        reset = 1'b1;
        mem1[50] = 32'h11112222;
        mem1[51] = 32'h33334444;
        tick();
        reset = 1'b0;
        drive(0, 1, 0, 32'hC8, '0);
        tick();
        check("b2b_read1", b_mem_read, 1);
        check("b2b_addr1", b_mem_addr, 32'hC8);
        tick();
        check("b2b_ready1", b_m0_ready, 1);
        check("b2b_data1", b_rdata, 32'h11112222);
        drive(0, 1, 0, 32'hCC, '0);
        tick();
        check("b2b_idle_ready", b_m0_ready, 0);
        check("b2b_idle_read", b_mem_read, 0);
        tick();
        check("b2b_read2", b_mem_read, 1);
        check("b2b_addr2", b_mem_addr, 32'hCC);
        tick();
        check("b2b_ready2", b_m0_ready, 1);
        check("b2b_data2", b_rdata, 32'h33334444);
        drive(0, 0, 0, '0, '0);
        tick();
        check("b2b_end", b_m0_ready, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
